// File: rtl/msk_g4_share_encoder.sv
// Producer side of the masked GF(4) multiplier: splits unmasked words into D-share
// bitsliced sharings and delivers them through a 2-entry elastic buffer.

module msk_g4_share_lane #(
  parameter int D = 2
) (
  input  logic [1:0]         i_x,
  input  logic [2*(D-1)-1:0] i_mask,
  output logic [D-1:0]       o_s0,
  output logic [D-1:0]       o_s1
);

  always_comb begin : comb_share
    logic [1:0] acc;
    acc  = i_x;
    o_s0 = '0;
    o_s1 = '0;
    for (int i = 1; i < D; i++) begin
      o_s0[i] = i_mask[2*(i-1)];
      o_s1[i] = i_mask[2*(i-1)+1];
      acc     = acc ^ i_mask[2*(i-1) +: 2];
    end
    o_s0[0] = acc[0];
    o_s1[0] = acc[1];
  end

endmodule

module msk_g4_share_encoder #(
  parameter int D = 2,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [2*N-1:0]       in_data,
  input  logic                 in_valid,
  input  logic [2*N*(D-1)-1:0] in_rnd,
  input  logic                 rnd_valid,
  output logic                 in_ready,
  output logic [N*D-1:0]       out0,
  output logic [N*D-1:0]       out1,
  output logic [N*D-1:0]       out0_prev,
  output logic [N*D-1:0]       out1_prev,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rnd_ready
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t         r_state, w_next;
  logic [N*D-1:0] w_sh0, w_sh1;
  logic [N*D-1:0] r_head0, r_head1, r_tail0, r_tail1, r_prev0, r_prev1;
  logic           w_acc, w_pop, w_ld_head_new, w_ld_head_tail, w_ld_tail;

  for (genvar k = 0; k < N; k++) begin : g_lane
    msk_g4_share_lane #(.D(D)) u_lane (
      .i_x    (in_data[2*k +: 2]),
      .i_mask (in_rnd[2*k*(D-1) +: 2*(D-1)]),
      .o_s0   (w_sh0[k*D +: D]),
      .o_s1   (w_sh1[k*D +: D])
    );
  end

  // Handshake flags are gated by nrst so nothing is accepted or offered in a reset cycle.
  assign in_ready  = nrst & (r_state != S_FULL);
  assign out_valid = nrst & (r_state != S_EMPTY);
  assign w_acc     = in_valid & rnd_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign rnd_ready = w_acc;

  always_comb begin
    w_next         = r_state;
    w_ld_head_new  = 1'b0;
    w_ld_head_tail = 1'b0;
    w_ld_tail      = 1'b0;
    case (r_state)
      S_EMPTY: if (w_acc) begin
        w_next        = S_ONE;
        w_ld_head_new = 1'b1;
      end
      S_ONE: begin
        if (w_acc && w_pop) begin
          w_ld_head_new = 1'b1;
        end else if (w_acc) begin
          w_next    = S_FULL;
          w_ld_tail = 1'b1;
        end else if (w_pop) begin
          w_next = S_EMPTY;
        end
      end
      S_FULL: if (w_pop) begin
        w_next         = S_ONE;
        w_ld_head_tail = 1'b1;
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_EMPTY;
      r_head0 <= '0;
      r_head1 <= '0;
      r_tail0 <= '0;
      r_tail1 <= '0;
      r_prev0 <= '0;
      r_prev1 <= '0;
    end else begin
      r_state <= w_next;
      r_prev0 <= r_head0;
      r_prev1 <= r_head1;
      if (w_ld_head_new) begin
        r_head0 <= w_sh0;
        r_head1 <= w_sh1;
      end else if (w_ld_head_tail) begin
        r_head0 <= r_tail0;
        r_head1 <= r_tail1;
      end
      if (w_ld_tail) begin
        r_tail0 <= w_sh0;
        r_tail1 <= w_sh1;
      end
    end
  end

  assign out0      = r_head0;
  assign out1      = r_head1;
  assign out0_prev = r_prev0;
  assign out1_prev = r_prev1;

endmodule
